// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, reads one word at a time
// from the icache and holds it on ins/ins_valid until decode accepts it.
// Accepting computes the next PC from pcSel. Accepting a halt stops fetching
// until reset.
//
// Ports:
//   CLK, nRST            clock; asynchronous active-low reset
//   iREN, iaddr          icache read request and word address (= pc)
//   ihit, iload          icache data-valid strobe and read data
//   ins, ins_valid       held instruction word and its valid flag
//   pc, npc              address of ins / fetch address, and pc + 4
//   ef                   decode accepts ins (only counts while ins_valid)
//   pcSel                next PC: 00 npc, 01 branch, 10 jump, 11 register
//   imm16, jr_addr       branch offset and jump-register target
//   halt, halted         decode flags ins as halt; fetch is stopped
//   cyc_cnt, stall_cnt   perf counters (only when FETCH_PERF_CNT_EN is defined)
//
// Build option: define FETCH_PERF_CNT_EN to add the cycle and stall counters.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             ihit,
  input  logic [31:0]      iload,
  output logic [31:0]      ins,
  output logic             ins_valid,
  output logic [31:0]      pc,
  output logic [31:0]      npc,
  input  logic             ef,
  input  logic [1:0]       pcSel,
  input  logic [15:0]      imm16,
  input  logic [31:0]      jr_addr,
  input  logic             halt,
  output logic             halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state, state_n;
  logic        req;      // FETCH is requesting; gated with nRST for iREN
  logic        load_ins; // capture iload this cycle
  logic        accept;   // decode consumed ins (halt or not)
  logic        pc_upd;   // accepted non-halt: move to next_pc
  logic [31:0] next_pc;
  logic [31:0] br_off;

  assign npc    = pc + 32'd4;
  assign iaddr  = pc;
  // Requests drop as soon as reset asserts, even though state already reads FETCH.
  assign iREN   = req & nRST;
  assign halted = (state == HALTED);
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    next_pc = npc;
    case (pcSel)
      2'b00:   next_pc = npc;
      2'b01:   next_pc = npc + br_off;
      2'b10:   next_pc = {npc[31:28], ins[25:0], 2'b00};
      default: next_pc = jr_addr;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    req      = 1'b0;
    load_ins = 1'b0;
    accept   = 1'b0;
    pc_upd   = 1'b0;
    case (state)
      FETCH: begin
        req = 1'b1;
        if (ihit) begin
          load_ins = 1'b1;
          state_n  = HOLD;
        end
      end
      HOLD: begin
        // ins_valid is always set in HOLD, so ef needs no extra qualification.
        if (ef) begin
          accept = 1'b1;
          if (halt) begin
            state_n = HALTED;
          end else begin
            pc_upd  = 1'b1;
            state_n = FETCH;
          end
        end
      end
      default: state_n = HALTED;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc        <= PC_INIT;
      ins       <= '0;
      ins_valid <= 1'b0;
    end else begin
      if (load_ins) begin
        ins       <= iload;
        ins_valid <= 1'b1;
      end else if (accept) begin
        ins_valid <= 1'b0;
      end
      if (pc_upd) pc <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (state != HALTED)             cyc_cnt   <= cyc_cnt + 1'b1;
      if ((state == FETCH) && !ihit)   stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic [31:0] ins;
  logic        ins_valid;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        ef;
  logic [1:0]  pcSel;
  logic [15:0] imm16;
  logic [31:0] jr_addr;
  logic        halt;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cyc_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .ins(ins), .ins_valid(ins_valid), .pc(pc), .npc(npc), .ef(ef), .pcSel(pcSel),
    .imm16(imm16), .jr_addr(jr_addr), .halt(halt), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Fetch one word at the current pc, then have decode accept it with sel.
  // Leaves the unit in FETCH at the new pc with ihit/ef low.
  task automatic step(input logic [1:0] sel, input logic [31:0] jr, input logic [31:0] word);
    ihit = 1'b1; iload = word; ef = 1'b0;
    tick();
    ihit = 1'b0; ef = 1'b1; pcSel = sel; jr_addr = jr;
    tick();
    ef = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; ihit = 1'b0; iload = '0; ef = 1'b0; pcSel = 2'b00;
    imm16 = '0; jr_addr = '0; halt = 1'b0;
    #2;
    total++; if (iREN !== 1'b0)      begin bad++; $display("FAIL rst_iren got=%b want=0", iREN); end
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ins_valid); end
    total++; if (pc !== 32'h0)       begin bad++; $display("FAIL rst_pc got=%h want=0", pc); end
    total++; if (halted !== 1'b0)    begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
    total++; if (ins !== 32'h0)      begin bad++; $display("FAIL rst_ins got=%h want=0", ins); end
    @(negedge CLK); nRST = 1'b1; #1;
    total++; if (iREN !== 1'b1 || iaddr !== 32'h0)
      begin bad++; $display("FAIL rst_first_req got=%b/%h want=1/0", iREN, iaddr); end
  endtask

  task automatic test_seq();
    ihit = 1'b1; iload = 32'h2401_0005; ef = 1'b1; pcSel = 2'b00;
    for (int k = 0; k < 3; k++) begin
      total++; if (iREN !== 1'b1 || iaddr !== 32'(4*k) || ins_valid !== 1'b0)
        begin bad++; $display("FAIL seq_fetch k=%0d got=%b/%h/%b want=1/%h/0", k, iREN, iaddr, ins_valid, 4*k); end
      tick();
      total++; if (ins_valid !== 1'b1 || iREN !== 1'b0 || ins !== 32'h2401_0005 || pc !== 32'(4*k))
        begin bad++; $display("FAIL seq_hold k=%0d got=%b/%b/%h/%h", k, ins_valid, iREN, ins, pc); end
      tick();
    end
    tick(); tick(); // one more instruction -> pc = 0x10
    ef = 1'b0;
  endtask

  task automatic test_stall();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] s0;
    s0 = stall_cnt;
`endif
    ihit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (iREN !== 1'b1 || iaddr !== 32'h10 || ins_valid !== 1'b0)
        begin bad++; $display("FAIL stall i=%0d got=%b/%h/%b want=1/00000010/0", i, iREN, iaddr, ins_valid); end
      tick();
    end
`ifdef FETCH_PERF_CNT_EN
    total++; if (stall_cnt !== s0 + 32'd5)
      begin bad++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, s0 + 5); end
`endif
  endtask

  task automatic test_branch_jump();
    step(2'b11, 32'h40, 32'h0);
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL jr_pc got=%h want=40", pc); end
    total++; if (npc !== 32'h44) begin bad++; $display("FAIL npc got=%h want=44", npc); end
    imm16 = 16'hFFFE;
    step(2'b01, 32'h0, 32'h0);
    total++; if (iaddr !== 32'h3C || iREN !== 1'b1)
      begin bad++; $display("FAIL branch got=%h/%b want=3c/1", iaddr, iREN); end
    step(2'b10, 32'h0, 32'h0000_0100);
    total++; if (iaddr !== 32'h400 || iREN !== 1'b1)
      begin bad++; $display("FAIL jump got=%h/%b want=400/1", iaddr, iREN); end
  endtask

  task automatic test_hold();
    ihit = 1'b1; iload = 32'hAAAA_5555; ef = 1'b0;
    tick();
    iload = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      ihit = i[0];
      tick();
      total++; if (ins !== 32'hAAAA_5555 || pc !== 32'h400 || iREN !== 1'b0 || ins_valid !== 1'b1)
        begin bad++; $display("FAIL hold i=%0d got=%h/%h/%b/%b", i, ins, pc, iREN, ins_valid); end
    end
    ihit = 1'b0; ef = 1'b1; pcSel = 2'b00;
    tick();
    ef = 1'b0;
    total++; if (pc !== 32'h404) begin bad++; $display("FAIL hold_release got=%h want=404", pc); end
  endtask

  task automatic test_wrap();
    step(2'b11, 32'hFFFF_FFFC, 32'h0);
    total++; if (npc !== 32'h0) begin bad++; $display("FAIL wrap_npc got=%h want=0", npc); end
    step(2'b00, 32'h0, 32'h0);
    total++; if (pc !== 32'h0 || iaddr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=0", pc); end
    step(2'b11, 32'h0000_0083, 32'h0);
    total++; if (pc !== 32'h83) begin bad++; $display("FAIL jr_lowbits got=%h want=83", pc); end
    step(2'b11, 32'h0000_0080, 32'h0);
  endtask

  task automatic test_halt();
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] c0;
`endif
    ihit = 1'b1; iload = 32'hFC00_0000;
    tick();
    ihit = 1'b0; ef = 1'b1; halt = 1'b1; pcSel = 2'b01; imm16 = 16'h0010;
    tick();
    total++; if (halted !== 1'b1 || pc !== 32'h80 || iREN !== 1'b0 || ins_valid !== 1'b0)
      begin bad++; $display("FAIL halt_enter got=%b/%h/%b/%b want=1/80/0/0", halted, pc, iREN, ins_valid); end
`ifdef FETCH_PERF_CNT_EN
    c0 = cyc_cnt;
`endif
    halt = 1'b0; pcSel = 2'b10;
    for (int i = 0; i < 6; i++) begin
      ihit = i[0]; ef = ~i[0];
      tick();
      total++; if (halted !== 1'b1 || pc !== 32'h80 || iREN !== 1'b0 || ins_valid !== 1'b0)
        begin bad++; $display("FAIL halt_stay i=%0d got=%b/%h/%b/%b", i, halted, pc, iREN, ins_valid); end
    end
`ifdef FETCH_PERF_CNT_EN
    total++; if (cyc_cnt !== c0) begin bad++; $display("FAIL cyc_freeze got=%0d want=%0d", cyc_cnt, c0); end
`endif
    ihit = 1'b0; ef = 1'b0;
  endtask

  task automatic test_reset_mid();
    nRST = 1'b0; #1;
    total++; if (halted !== 1'b0 || pc !== 32'h0) begin bad++; $display("FAIL unhalt got=%b/%h", halted, pc); end
    @(negedge CLK); nRST = 1'b1; #1;
    step(2'b11, 32'h24, 32'h0);
    tick(); // one stall cycle at 0x24
    total++; if (iaddr !== 32'h24 || iREN !== 1'b1) begin bad++; $display("FAIL pre_mid got=%h/%b want=24/1", iaddr, iREN); end
    ihit = 1'b1; iload = 32'hDEAD_BEEF;
    #2 nRST = 1'b0;
    #1;
    total++; if (pc !== 32'h0 || ins_valid !== 1'b0 || iREN !== 1'b0 || ins !== 32'h0)
      begin bad++; $display("FAIL mid_rst got=%h/%b/%b/%h want=0/0/0/0", pc, ins_valid, iREN, ins); end
    @(negedge CLK); ihit = 1'b0; nRST = 1'b1; #1;
    total++; if (iaddr !== 32'h0 || iREN !== 1'b1) begin bad++; $display("FAIL post_rst got=%h/%b want=0/1", iaddr, iREN); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (cyc_cnt !== 32'h0 || stall_cnt !== 32'h0)
      begin bad++; $display("FAIL cnt_rst got=%0d/%0d want=0/0", cyc_cnt, stall_cnt); end
`endif
    ihit = 1'b1; iload = 32'h0BAD_F00D;
    tick();
    total++; if (ins_valid !== 1'b1 || ins !== 32'h0BAD_F00D || pc !== 32'h0)
      begin bad++; $display("FAIL post_rst_fetch got=%b/%h/%h", ins_valid, ins, pc); end
    ihit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_stall();
    test_branch_jump();
    test_hold();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
